host_bus_initiator: RTL and testbench

HOST_BUS_INITIATOR -- requirements
Module: host_bus_initiator

---
 rtl/host_bus_initiator_pkg.sv | 20 ++
 rtl/host_bus_initiator.sv | 171 +++++++++++++++++
 tb/tb_host_bus_initiator.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_bus_initiator_pkg.sv
// Shared constants for the host command bridge: opcodes, response bytes and FSM states.
package host_bus_initiator_pkg;

    localparam logic [7:0] OpRead      = 8'h52;  // 'R'
    localparam logic [7:0] OpWrite     = 8'h57;  // 'W'
    localparam logic [7:0] RespBadOp   = 8'h3F;  // '?'
    localparam logic [7:0] RespOk      = 8'h4B;  // 'K'
    localparam logic [7:0] RespTimeout = 8'h54;  // 'T'

    typedef enum logic [2:0] {
        StOpcode,
        StAddrHi,
        StAddrLo,
        StWdata,
        StBusReq,
        StWaitAck,
        StResp
    } state_e;

endpackage

// File: rtl/host_bus_initiator.sv
// Host byte-stream to register-bus bridge: parses R/W commands from the rx FIFO, runs one
// bus cycle and returns a response (ack, read data, timeout or bad-opcode) on the tx FIFO.
module host_bus_initiator
    import host_bus_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_request,
    output logic        o_write,
    input  logic        i_busy,
    input  logic        i_ack,
    output logic [10:0] o_address,
    output logic [31:0] o_data,
    input  logic [31:0] i_data,
    output logic        o_timeout
);

    localparam int unsigned CntW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    state_e            state_q;
    logic              rx_ready_q;
    logic [1:0]        byte_cnt_q;   // wdata bytes taken, or resp bytes still queued
    logic [CntW-1:0]   wait_cnt_q;
    logic [31:0]       resp_q;       // remaining read-data bytes, MSB aligned
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              request_q;
    logic              write_q;
    logic [10:0]       address_q;
    logic [31:0]       data_q;
    logic              timeout_q;
    logic              rx_fire;
    logic              tx_fire;

    // Ready is forced low while reset is applied so no byte is accepted in the reset cycle.
    assign o_rx_ready = rx_ready_q & ~i_reset;
    assign rx_fire    = i_rx_valid & o_rx_ready;
    assign tx_fire    = tx_valid_q & i_tx_ready;

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_request  = request_q;
    assign o_write    = write_q;
    assign o_address  = address_q;
    assign o_data     = data_q;
    assign o_timeout  = timeout_q;

    // Command FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StOpcode;
            rx_ready_q <= 1'b1;
            byte_cnt_q <= 2'd0;
            wait_cnt_q <= '0;
            resp_q     <= 32'd0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            request_q  <= 1'b0;
            write_q    <= 1'b0;
            address_q  <= 11'd0;
            data_q     <= 32'd0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                StOpcode: begin
                    if (rx_fire) begin
                        if (i_rx_data == OpRead || i_rx_data == OpWrite) begin
                            write_q <= (i_rx_data == OpWrite);
                            state_q <= StAddrHi;
                        end else begin
                            rx_ready_q <= 1'b0;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= RespBadOp;
                            byte_cnt_q <= 2'd0;
                            state_q    <= StResp;
                        end
                    end
                end
                StAddrHi: begin
                    if (rx_fire) begin
                        address_q[10:8] <= i_rx_data[2:0];
                        state_q         <= StAddrLo;
                    end
                end
                StAddrLo: begin
                    if (rx_fire) begin
                        address_q[7:0] <= i_rx_data;
                        byte_cnt_q     <= 2'd0;
                        if (write_q) begin
                            state_q <= StWdata;
                        end else begin
                            rx_ready_q <= 1'b0;
                            request_q  <= 1'b1;
                            state_q    <= StBusReq;
                        end
                    end
                end
                StWdata: begin
                    if (rx_fire) begin
                        data_q     <= {data_q[23:0], i_rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            rx_ready_q <= 1'b0;
                            request_q  <= 1'b1;
                            state_q    <= StBusReq;
                        end
                    end
                end
                StBusReq: begin
                    // Busy stalls the request indefinitely; the timeout only covers the ack.
                    if (!i_busy) begin
                        request_q <= 1'b0;
                        if (write_q) begin
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= RespOk;
                            byte_cnt_q <= 2'd0;
                            state_q    <= StResp;
                        end else begin
                            wait_cnt_q <= '0;
                            state_q    <= StWaitAck;
                        end
                    end
                end
                StWaitAck: begin
                    if (i_ack) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= i_data[31:24];
                        resp_q     <= {i_data[23:0], 8'h00};
                        byte_cnt_q <= 2'd3;
                        state_q    <= StResp;
                    end else if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q  <= 1'b1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= RespTimeout;
                        byte_cnt_q <= 2'd0;
                        state_q    <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    if (tx_fire) begin
                        if (byte_cnt_q == 2'd0) begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state_q    <= StOpcode;
                        end else begin
                            tx_data_q  <= resp_q[31:24];
                            resp_q     <= {resp_q[23:0], 8'h00};
                            byte_cnt_q <= byte_cnt_q - 2'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StOpcode;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_bus_initiator.sv
// Scoreboard bench for host_bus_initiator: expected bus cycles and tx bytes are queued as
// commands are driven and compared when the DUT presents them.
module tb_host_bus_initiator;

    localparam int unsigned Timeout = 8;

    typedef struct {
        logic        wr;
        logic [10:0] addr;
        logic [31:0] data;
        logic        chk_data;
    } bus_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        request;
    logic        write;
    logic        busy;
    logic        ack;
    logic [10:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int tx_count = 0;
    int req_cycles = 0;
    int timeouts = 0;

    bus_exp_t   exp_bus[$];
    logic [7:0] exp_tx[$];

    host_bus_initiator #(.TIMEOUT_CYCLES(Timeout)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_rx_ready (rx_ready),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_request  (request),
        .o_write    (write),
        .i_busy     (busy),
        .i_ack      (ack),
        .o_address  (address),
        .o_data     (wdata),
        .i_data     (rdata),
        .o_timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: compare bus acceptances and tx transfers against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (request) req_cycles++;
            if (timeout) timeouts++;
            if (request && !busy) begin
                accepts++;
                if (exp_bus.size() == 0) begin
                    check_eq("bus_unexpected", 32'd0, 32'd1);
                end else begin
                    bus_exp_t e;
                    e = exp_bus.pop_front();
                    check_eq("bus_write", {31'd0, write}, {31'd0, e.wr});
                    check_eq("bus_addr", {21'd0, address}, {21'd0, e.addr});
                    if (e.chk_data) check_eq("bus_data", wdata, e.data);
                end
            end
            if (tx_valid && tx_ready) begin
                tx_count++;
                if (exp_tx.size() == 0) begin
                    check_eq("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] b;
                    b = exp_tx.pop_front();
                    check_eq("tx_byte", {24'd0, tx_data}, {24'd0, b});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        do begin
            @(negedge clk);
            rdy = rx_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) check_eq("rx_accept_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    // Ack a read `delay` cycles after the bus accepts it (delay 1 = zero wait states).
    task automatic ack_read(input int delay, input logic [31:0] d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(request && !busy) && n < 200);
        if (n >= 200) check_eq("read_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        repeat (delay - 1) begin
            @(posedge clk);
            #1;
        end
        ack   = 1'b1;
        rdata = d;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || tx_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check_eq("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic bus_exp_t mk_bus(logic wr, logic [10:0] a, logic [31:0] d, logic cd);
        bus_exp_t e;
        e.wr       = wr;
        e.addr     = a;
        e.data     = d;
        e.chk_data = cd;
        return e;
    endfunction

    initial begin
        int acc0;
        int tx0;
        rst      = 1'b1;
        rx_data  = 8'd0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        busy     = 1'b0;
        ack      = 1'b0;
        rdata    = 32'd0;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_eq("rst_request", {31'd0, request}, 32'd0);
        check_eq("rst_write", {31'd0, write}, 32'd0);
        check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
        check_eq("rst_address", {21'd0, address}, 32'd0);
        check_eq("rst_data", wdata, 32'd0);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Write 0x12345678 to 0x004.
        exp_bus.push_back(mk_bus(1'b1, 11'h004, 32'h1234_5678, 1'b1));
        exp_tx.push_back(8'h4B);
        send_cmd('{8'h57, 8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78});
        wait_idle();

        // Zero-wait read; high address bits [7:3] are ignored.
        exp_bus.push_back(mk_bus(1'b0, 11'h002, 32'd0, 1'b0));
        exp_tx.push_back(8'h53);
        exp_tx.push_back(8'h36);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h61);
        send_cmd('{8'h52, 8'hF8, 8'h02});
        ack_read(1, 32'h5336_3461);
        wait_idle();

        // Busy for 10 cycles during a write: request held with stable fields.
        busy = 1'b1;
        req_cycles = 0;
        acc0 = accepts;
        exp_bus.push_back(mk_bus(1'b1, 11'h7FF, 32'hA55A_0FF0, 1'b1));
        exp_tx.push_back(8'h4B);
        send_cmd('{8'h57, 8'h07, 8'hFF, 8'hA5, 8'h5A, 8'h0F, 8'hF0});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (request !== 1'b1 || address !== 11'h7FF || wdata !== 32'hA55A_0FF0 ||
                write !== 1'b1) begin
                check_eq("busy_hold", {request, write, 9'd0, address, 20'd0}, 32'hC3FF_0000);
            end
            @(posedge clk);
            #1;
        end
        busy = 1'b0;
        wait_idle();
        check_eq("busy_req_cycles", req_cycles, 32'd11);
        check_eq("busy_accepts", accepts - acc0, 32'd1);

        // Read with no ack times out; a late ack is ignored.
        timeouts = 0;
        tx0 = tx_count;
        exp_bus.push_back(mk_bus(1'b0, 11'h155, 32'd0, 1'b0));
        exp_tx.push_back(8'h54);
        send_cmd('{8'h52, 8'h01, 8'h55});
        wait_idle();
        ack   = 1'b1;
        rdata = 32'hDEAD_0001;
        repeat (3) @(posedge clk);
        #1;
        ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("timeout_pulses", timeouts, 32'd1);
        check_eq("timeout_tx_count", tx_count - tx0, 32'd1);
        exp_bus.push_back(mk_bus(1'b1, 11'h310, 32'hDEAD_BEEF, 1'b1));
        exp_tx.push_back(8'h4B);
        send_cmd('{8'h57, 8'h03, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
        wait_idle();

        // Bad opcode with tx back-pressure.
        tx_ready = 1'b0;
        exp_tx.push_back(8'h3F);
        send_byte(8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bad_op_tx", {22'd0, tx_valid, rx_ready, tx_data}, {22'd0, 1'b1, 1'b0, 8'h3F});
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        wait_idle();

        // Reset mid-write discards the command.
        acc0 = accepts;
        tx0  = tx_count;
        send_cmd('{8'h57, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("rst_mid_accepts", accepts - acc0, 32'd0);
        check_eq("rst_mid_tx", tx_count - tx0, 32'd0);

        // Following read with a 3-cycle ack delay, sent back-to-back with a write.
        exp_bus.push_back(mk_bus(1'b0, 11'h020, 32'd0, 1'b0));
        exp_tx.push_back(8'hCA);
        exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'hF0);
        exp_tx.push_back(8'h0D);
        send_cmd('{8'h52, 8'h00, 8'h20});
        ack_read(3, 32'hCAFE_F00D);
        exp_bus.push_back(mk_bus(1'b1, 11'h0AB, 32'h0102_0304, 1'b1));
        exp_tx.push_back(8'h4B);
        send_cmd('{8'h57, 8'h00, 8'hAB, 8'h01, 8'h02, 8'h03, 8'h04});
        wait_idle();

        check_eq("bus_queue_left", exp_bus.size(), 32'd0);
        check_eq("tx_queue_left", exp_tx.size(), 32'd0);
        check_eq("total_accepts", accepts, 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
